sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream stage of the 8-bit adder. Consumes its 9-bit sums over a valid/ready
//  handshake and accumulates a frame of up to BEATS sums. A frame also ends early on
//  last_i. Emits the frame total, the beat count and a sticky overflow flag over a
//  second valid/ready handshake, then clears and starts the next frame.
// PARAMETERS
//  DATA_W  9  width of incoming sum (adder output width)
//  ACC_W   16 accumulator/result width; ACC_W >= DATA_W
//  BEATS   4  max beats per frame; >= 1
// PORTS
//  clk      in   1                      clock, rising edge
//  rstn     in   1                      synchronous reset, active-low
//  valid_i  in   1                      input beat valid (from adder valid_o)
//  ready_i  out  1                      block can accept a beat (to adder ready_o)
//  data_i   in   DATA_W                 input sum
//  last_i   in   1                      beat closes the frame (sampled with data_i)
//  valid_o  out  1                      frame result valid
//  ready_o  in   1                      downstream accepts result
//  acc_o    out  ACC_W                  frame total, modulo 2**ACC_W
//  count_o  out  $clog2(BEATS+1)        beats accumulated in the frame
//  ovf_o    out  1                      carry lost out of ACC_W during the frame
// BEHAVIOUR
//  - Reset is synchronous; rstn is sampled at posedge clk.
//  - Reset values: ready_i=1, valid_o=0, acc_o=0, count_o=0, ovf_o=0, state=ACCUM.
//  - Reset mid-frame or mid-output discards all partial data. There is no flush.
//  - All outputs are registered. No combinational path from any input to any output.
//  - FSM has two states.
//    - ACCUM: ready_i=1, valid_o=0.
//    - OUTPUT: ready_i=0, valid_o=1.
//  - ACCUM, when valid_i && ready_i at an edge:
//    - acc_o <= acc_o + zero-extended data_i, truncated to ACC_W.
//    - ovf_o <= ovf_o | carry-out of that add.
//    - count_o <= count_o + 1.
//    - If last_i == 1 or count_o+1 == BEATS: go to OUTPUT. valid_o=1 and ready_i=0
//      on the next cycle.
//  - In ACCUM with valid_i=0, nothing changes. last_i without valid_i is ignored.
//  - Latency: the result is valid 1 cycle after the final beat's handshake edge.
//  - OUTPUT:
//    - acc_o, count_o and ovf_o are held stable while valid_o && !ready_o,
//      for any number of cycles.
//    - valid_i is ignored, and data_i/last_i are don't-care.
//  - OUTPUT, on valid_o && ready_o at an edge:
//    - acc_o, count_o and ovf_o are cleared to 0.
//    - valid_o <= 0, ready_i <= 1, go to ACCUM.
//    - A valid_i present in that same cycle is NOT accepted (ready_i was 0).
//  - Throughput: at most one beat per cycle. Minimum frame period is beats+1 cycles.
//  - BEATS=1: every accepted beat produces a result with count_o=1.
//  - Wrap: acc_o wraps modulo 2**ACC_W. ovf_o stays set until the result handshake.
//  - count_o never exceeds BEATS and never equals 0 while valid_o=1.
// STRUCTURE
//  - Shared package sum_acc_pkg holds:
//    - typedef enum logic {ACCUM, OUTPUT} sum_acc_state_e
//    - localparams SUM_W=9 and OPERAND_W=8, shared with the adder stage.
//  - Flat module: one always_ff for the FSM and datapath, one always_comb for the
//    next-sum/carry.
//  - No sub-module; the datapath is a single adder plus register.
//  - Count width comes from the localparam CNT_W = $clog2(BEATS+1).
// TESTING
//  1. Reset: hold rstn=0 for 3 cycles -> ready_i=1, valid_o=0, acc_o=0, count_o=0,
//     ovf_o=0.
//  2. Full frame (defaults): 4 beats of 0x1FE, ready_o=1 -> valid_o 1 cycle after
//     beat 4. acc_o=0x7F8, count_o=4, ovf_o=0. ready_i=1 on the following cycle.
//  3. Early end: beats 0x003, then 0x005 with last_i=1 -> acc_o=0x008, count_o=2;
//     the next frame starts from 0.
//  4. Overflow (ACC_W=10): 4 beats of 0x1FF -> acc_o=0x3FC, ovf_o=1. The next frame
//     of 4x0x001 -> acc_o=0x004, ovf_o=0.
//  5. Backpressure: ready_o=0 for 5 cycles with valid_i=1 and random data_i -> valid_o
//     held, outputs stable, no beat absorbed. On release, the first new beat is taken
//     1 cycle later.
//  6. Reset mid-frame: after 2 beats of 0x010, pulse rstn=0 -> outputs return to reset
//     values. Then 4 beats of 0x001 -> acc_o=0x004, count_o=4.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// ============================================================================
// Module      : sum_acc_pkg
// Description : Types and widths shared by the adder stage and the accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sum_acc_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } sum_acc_state_e;

    localparam int SUM_W     = 9;
    localparam int OPERAND_W = 8;

endpackage : sum_acc_pkg

`default_nettype wire

// File: rtl/sum_accumulator.sv
// ============================================================================
// Module      : sum_accumulator
// Description : Accumulates up to BEATS adder sums per frame and hands the
//               total, beat count and sticky overflow flag downstream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = SUM_W,
    parameter int ACC_W  = 16,
    parameter int BEATS  = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         valid_i,
    output logic                         ready_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         last_i,
    output logic                         valid_o,
    input  logic                         ready_o,
    output logic [ACC_W-1:0]             acc_o,
    output logic [$clog2(BEATS+1)-1:0]   count_o,
    output logic                         ovf_o
);

    localparam int CNT_W = $clog2(BEATS+1);

    sum_acc_state_e     r_state;
    logic               r_ready;
    logic               r_valid;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_frame_end;

    // One extra bit on the adder captures the carry that wraps out of ACC_W.
    always_comb begin
        w_sum       = {1'b0, r_acc} + {{(ACC_W+1-DATA_W){1'b0}}, data_i};
        w_cnt_next  = r_cnt + 1'b1;
        w_frame_end = last_i || (w_cnt_next == CNT_W'(BEATS));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ACCUM;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (valid_i && r_ready) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        r_cnt <= w_cnt_next;
                        if (w_frame_end) begin
                            r_state <= OUTPUT;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                OUTPUT: begin
                    // Result is held until taken; input beats are not accepted here.
                    if (r_valid && ready_o) begin
                        r_state <= ACCUM;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign ready_i = r_ready;
    assign valid_o = r_valid;
    assign acc_o   = r_acc;
    assign count_o = r_cnt;
    assign ovf_o   = r_ovf;

endmodule : sum_accumulator

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Directed self-checking bench for sum_accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rstn;

    // Default-width instance
    logic        valid_i, last_i, ready_o;
    logic [8:0]  data_i;
    logic        ready_i, valid_o, ovf_o;
    logic [15:0] acc_o;
    logic [2:0]  count_o;

    // Narrow accumulator instance for wrap/overflow
    logic        b_valid_i, b_last_i, b_ready_o;
    logic [8:0]  b_data_i;
    logic        b_ready_i, b_valid_o, b_ovf_o;
    logic [9:0]  b_acc_o;
    logic [2:0]  b_count_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.DATA_W(9), .ACC_W(16), .BEATS(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i), .last_i(last_i),
        .valid_o(valid_o), .ready_o(ready_o),
        .acc_o(acc_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    sum_accumulator #(.DATA_W(9), .ACC_W(10), .BEATS(4)) u_dut_narrow (
        .clk(clk), .rstn(rstn),
        .valid_i(b_valid_i), .ready_i(b_ready_i), .data_i(b_data_i), .last_i(b_last_i),
        .valid_o(b_valid_o), .ready_o(b_ready_o),
        .acc_o(b_acc_o), .count_o(b_count_o), .ovf_o(b_ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [8:0] d, input logic l);
        valid_i = 1'b1; data_i = d; last_i = l;
        step();
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic beat_b(input logic [8:0] d);
        b_valid_i = 1'b1; b_data_i = d;
        step();
        b_valid_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] a,
                             input logic [2:0] c, input logic o);
        check({tag, ".valid_o"}, 32'(valid_o), 32'(v));
        check({tag, ".ready_i"}, 32'(ready_i), 32'(!v));
        check({tag, ".acc_o"},   32'(acc_o),   32'(a));
        check({tag, ".count_o"}, 32'(count_o), 32'(c));
        check({tag, ".ovf_o"},   32'(ovf_o),   32'(o));
    endtask

    initial begin
        rstn = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = '0; ready_o = 1'b1;
        b_valid_i = 1'b0; b_last_i = 1'b0; b_data_i = '0; b_ready_o = 1'b1;
        #2;
        repeat (3) step();
        check_out("reset", 1'b0, 16'h0000, 3'd0, 1'b0);
        rstn = 1'b1;
        step();

        // Full frame of four 0x1FE beats
        beat(9'h1FE, 1'b0);
        beat(9'h1FE, 1'b0);
        beat(9'h1FE, 1'b0);
        check_out("full.pre", 1'b0, 16'h05FA, 3'd3, 1'b0);
        beat(9'h1FE, 1'b0);
        check_out("full.result", 1'b1, 16'h07F8, 3'd4, 1'b0);
        step();
        check_out("full.cleared", 1'b0, 16'h0000, 3'd0, 1'b0);

        // Early end on last_i; last_i without valid_i is ignored
        last_i = 1'b1;
        step();
        check_out("last_novalid", 1'b0, 16'h0000, 3'd0, 1'b0);
        beat(9'h003, 1'b0);
        beat(9'h005, 1'b1);
        check_out("early.result", 1'b1, 16'h0008, 3'd2, 1'b0);
        step();
        check_out("early.cleared", 1'b0, 16'h0000, 3'd0, 1'b0);
        beat(9'h007, 1'b1);
        check_out("early.next", 1'b1, 16'h0007, 3'd1, 1'b0);
        step();

        // Backpressure: result held, concurrent beats not absorbed
        ready_o = 1'b0;
        beat(9'h010, 1'b0);
        beat(9'h020, 1'b0);
        beat(9'h030, 1'b0);
        beat(9'h040, 1'b0);
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = 9'($urandom_range(0, 511));
            last_i = 1'($urandom_range(0, 1));
            step();
            check_out("bp.hold", 1'b1, 16'h00A0, 3'd4, 1'b0);
        end
        ready_o = 1'b1; data_i = 9'h011; last_i = 1'b1;
        step();
        check_out("bp.release", 1'b0, 16'h0000, 3'd0, 1'b0);
        step();
        valid_i = 1'b0; last_i = 1'b0;
        check_out("bp.newbeat", 1'b1, 16'h0011, 3'd1, 1'b0);
        step();

        // Reset mid-frame discards partial data
        beat(9'h010, 1'b0);
        beat(9'h010, 1'b0);
        check_out("midrst.partial", 1'b0, 16'h0020, 3'd2, 1'b0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_out("midrst.reset", 1'b0, 16'h0000, 3'd0, 1'b0);
        repeat (4) beat(9'h001, 1'b0);
        check_out("midrst.frame", 1'b1, 16'h0004, 3'd4, 1'b0);
        step();

        // Overflow on the 10-bit accumulator: 0x1FF*4 = 0x7FC -> 0x3FC with carry
        repeat (4) beat_b(9'h1FF);
        check("ovf.valid_o", 32'(b_valid_o), 32'd1);
        check("ovf.acc_o",   32'(b_acc_o),   32'h3FC);
        check("ovf.count_o", 32'(b_count_o), 32'd4);
        check("ovf.ovf_o",   32'(b_ovf_o),   32'd1);
        step();
        check("ovf.cleared", 32'(b_ovf_o), 32'd0);
        repeat (4) beat_b(9'h001);
        check("ovf.next.acc_o", 32'(b_acc_o), 32'h004);
        check("ovf.next.ovf_o", 32'(b_ovf_o), 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sum_accumulator

`default_nettype wire
